// File: rtl/pc_stack_unit.sv
// Call/return stack sequencer: moves a 12-bit return address between the core and RAM page STACK_PAGE
// as three nibbles. Define PC_STACK_GUARD_EN to enable the sticky stack_fault wrap detector.
module pc_stack_unit #(
  parameter logic [3:0] STACK_PAGE = 4'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_push,
  input  logic        start_pop,
  input  logic        pop_skip,
  input  logic [11:0] push_pc,
  input  logic        sp_load,
  input  logic [7:0]  sp_load_data,
  output logic [11:0] mem_addr,
  output logic [3:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [3:0]  mem_rdata,
  output logic [7:0]  sp,
  output logic [11:0] pc_out,
  output logic        busy,
  output logic        done,
  output logic        stack_fault
);

  typedef enum logic [2:0] {
    IDLE, PUSH_PCP, PUSH_PSH, PUSH_PSL, POP_PSL, POP_PSH, POP_PCP, POP_CAP
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] push_data;
  logic        skip_flag;
  logic [3:0]  psl_nib, psh_nib;
  logic        idle, take_push, take_pop, take_load;

  function automatic logic [11:0] pc_advance(input logic [11:0] pc, input logic skip);
    return pc + {11'd0, skip};
  endfunction

  assign idle      = (state == IDLE);
  assign take_push = idle && start_push;
  assign take_pop  = idle && !start_push && start_pop;
  assign take_load = idle && !start_push && !start_pop && sp_load;
  assign busy      = !idle;

  // Memory strobes are decoded straight from state, so IDLE/POP_CAP (and reset) drive all zeros.
  always_comb begin
    state_nxt = state;
    mem_addr  = 12'h000;
    mem_wdata = 4'h0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      IDLE: begin
        if (take_push)     state_nxt = PUSH_PCP;
        else if (take_pop) state_nxt = POP_PSL;
      end
      PUSH_PCP: begin
        mem_addr  = {STACK_PAGE, sp - 8'd1};
        mem_wdata = push_data[11:8];
        mem_we    = 1'b1;
        state_nxt = PUSH_PSH;
      end
      PUSH_PSH: begin
        mem_addr  = {STACK_PAGE, sp - 8'd2};
        mem_wdata = push_data[7:4];
        mem_we    = 1'b1;
        state_nxt = PUSH_PSL;
      end
      PUSH_PSL: begin
        mem_addr  = {STACK_PAGE, sp - 8'd3};
        mem_wdata = push_data[3:0];
        mem_we    = 1'b1;
        state_nxt = IDLE;
      end
      POP_PSL: begin
        mem_addr  = {STACK_PAGE, sp};
        mem_re    = 1'b1;
        state_nxt = POP_PSH;
      end
      POP_PSH: begin
        mem_addr  = {STACK_PAGE, sp + 8'd1};
        mem_re    = 1'b1;
        state_nxt = POP_PCP;
      end
      POP_PCP: begin
        mem_addr  = {STACK_PAGE, sp + 8'd2};
        mem_re    = 1'b1;
        state_nxt = POP_CAP;
      end
      POP_CAP:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sp     <= 8'h00;
      pc_out <= 12'h000;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == PUSH_PSL) || (state == POP_CAP);
      if (take_load)               sp <= sp_load_data;
      else if (state == PUSH_PSL)  sp <= sp - 8'd3;
      else if (state == POP_CAP)   sp <= sp + 8'd3;
      // PCP nibble read in POP_PCP arrives on mem_rdata during POP_CAP.
      if (state == POP_CAP) pc_out <= pc_advance({mem_rdata, psh_nib, psl_nib}, skip_flag);
    end
  end

  // Operand and nibble capture registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (take_push)           push_data <= push_pc;
    if (take_pop)            skip_flag <= pop_skip;
    if (state == POP_PSH)    psl_nib   <= mem_rdata;
    if (state == POP_PCP)    psh_nib   <= mem_rdata;
  end

`ifdef PC_STACK_GUARD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stack_fault <= 1'b0;
    end else if ((take_push && (sp < 8'h03)) || (take_pop && (sp > 8'hFC))) begin
      stack_fault <= 1'b1;
    end
  end
`else
  assign stack_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: vector table, directed corner sequences and random ops against a stack model.
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_push, start_pop, pop_skip, sp_load;
  logic [11:0] push_pc;
  logic [7:0]  sp_load_data;
  logic [11:0] mem_addr;
  logic [3:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [3:0]  mem_rdata = 4'h0;
  logic [7:0]  sp;
  logic [11:0] pc_out;
  logic        busy, done, stack_fault;

  always #5 clk = ~clk;

  pc_stack_unit #(.STACK_PAGE(4'h0)) dut (
    .clk(clk), .reset_n(reset_n), .start_push(start_push), .start_pop(start_pop),
    .pop_skip(pop_skip), .push_pc(push_pc), .sp_load(sp_load), .sp_load_data(sp_load_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .sp(sp), .pc_out(pc_out), .busy(busy), .done(done),
    .stack_fault(stack_fault)
  );

  // Data RAM attached to the DUT: synchronous write, read data valid the cycle after mem_re.
  logic [3:0] ram [4096] = '{default: 4'h0};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Reference model: stack page image, stack pointer, last popped PC, sticky fault.
  logic [3:0]  ref_mem [256];
  logic [7:0]  ref_sp;
  logic [11:0] ref_pc;
  bit          ref_fault;
  bit          guard_on;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic load_sp(input logic [7:0] v);
    @(negedge clk);
    sp_load = 1'b1; sp_load_data = v;
    @(negedge clk);
    sp_load = 1'b0;
    ref_sp = v;
    chk("sp_load", {24'd0, sp}, {24'd0, v});
  endtask

  // Run one operation and check the access sequence, latency, and final state against the model.
  task automatic exec(input bit p, input bit q, input bit sk, input logic [11:0] pc, input bit inject);
    logic [7:0]  ea [3];
    logic [3:0]  ed [3];
    logic [11:0] ga [4];
    logic [3:0]  gd [4];
    bit          gw [4];
    int          exp_k, n, dk;
    logic [7:0]  a;
    bit          is_push;
    is_push = p;
    for (int i = 0; i < 3; i++) begin
      ea[i] = is_push ? ref_sp - 8'(i + 1) : ref_sp + 8'(i);
    end
    ed[0] = pc[11:8]; ed[1] = pc[7:4]; ed[2] = pc[3:0];
    exp_k = is_push ? 4 : 5;
    if (guard_on && ((is_push && ref_sp < 8'h03) || (!is_push && ref_sp > 8'hFC))) ref_fault = 1'b1;

    @(negedge clk);
    start_push = p; start_pop = q; pop_skip = sk; push_pc = pc;
    @(negedge clk);
    start_push = 1'b0; start_pop = 1'b0; pop_skip = 1'b0;
    n = 0; dk = 0;
    for (int k = 1; k <= 8 && dk == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (inject && k == 2) begin
        start_push = 1'b1; start_pop = 1'b1; sp_load = 1'b1; sp_load_data = 8'h99;
      end
      if (inject && k == 3) begin
        start_push = 1'b0; start_pop = 1'b0; sp_load = 1'b0;
      end
      if (mem_we && mem_re) chk("we_re_exclusive", 32'd1, 32'd0);
      if (mem_we || mem_re) begin
        if (n < 4) begin ga[n] = mem_addr; gd[n] = mem_wdata; gw[n] = mem_we; end
        n++;
      end
      if (done) dk = k;
    end
    chk("done_latency", dk, exp_k);
    chk("access_count", n, 3);
    for (int i = 0; i < 3 && i < n; i++) begin
      chk("access_addr", {20'd0, ga[i]}, {24'd0, ea[i]});
      chk("access_write", {31'd0, gw[i]}, {31'd0, is_push});
      if (is_push) chk("access_wdata", {28'd0, gd[i]}, {28'd0, ed[i]});
    end

    if (is_push) begin
      for (int i = 0; i < 3; i++) ref_mem[ea[i]] = ed[i];
      ref_sp = ref_sp - 8'd3;
    end else begin
      a = ref_sp;
      ref_pc = {ref_mem[8'(a + 8'd2)], ref_mem[8'(a + 8'd1)], ref_mem[a]} + 12'(sk);
      ref_sp = ref_sp + 8'd3;
    end
    chk("final_sp", {24'd0, sp}, {24'd0, ref_sp});
    chk("final_pc_out", {20'd0, pc_out}, {20'd0, ref_pc});
    chk("stack_fault", {31'd0, stack_fault}, {31'd0, ref_fault});
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    if (inject) begin
      @(negedge clk);
      chk("ignored_while_busy", {31'd0, busy}, 32'd0);
      chk("sp_after_ignore", {24'd0, sp}, {24'd0, ref_sp});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sp"}, {24'd0, sp}, 32'd0);
    chk({tag, "_pc_out"}, {20'd0, pc_out}, 32'd0);
    chk({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {28'd0, mem_wdata}, 32'd0);
    chk({tag, "_strobes"}, {28'd0, mem_we, mem_re, busy, done}, 32'd0);
    chk({tag, "_fault"}, {31'd0, stack_fault}, 32'd0);
  endtask

  typedef struct {
    bit          push;
    bit          skip;
    logic [7:0]  sp0;
    logic [11:0] pc;
    logic [11:0] exp_pc;
    logic [7:0]  exp_sp;
    bit          exp_fault_guarded;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h47, 12'h74D, 12'h000, 8'h44, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h44, 12'h000, 12'h74D, 8'h47, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h44, 12'h000, 12'h74E, 8'h47, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h47, 12'h74E, 12'h74E, 8'h44, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h44, 12'h000, 12'h74E, 8'h47, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h47, 12'hFFF, 12'h74E, 8'h44, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h44, 12'h000, 12'h000, 8'h47, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h01, 12'hABC, 12'h000, 8'hFE, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'hFE, 12'h000, 12'hABC, 8'h01, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h10, 12'h123, 12'hABC, 8'h0D, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'h0D, 12'h000, 12'h124, 8'h10, 1'b1};

`ifdef PC_STACK_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = 4'h0;
    ref_sp = 8'h00; ref_pc = 12'h000; ref_fault = 1'b0;
    reset_n = 1'b0; start_push = 1'b0; start_pop = 1'b0; pop_skip = 1'b0;
    sp_load = 1'b0; sp_load_data = 8'h00; push_pc = 12'h000;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      load_sp(vecs[i].sp0);
      exec(vecs[i].push, !vecs[i].push, vecs[i].skip, vecs[i].pc, 1'b0);
      chk($sformatf("vec%0d_pc_out", i), {20'd0, pc_out}, {20'd0, vecs[i].exp_pc});
      chk($sformatf("vec%0d_sp", i), {24'd0, sp}, {24'd0, vecs[i].exp_sp});
      chk($sformatf("vec%0d_fault", i), {31'd0, stack_fault},
          {31'd0, vecs[i].exp_fault_guarded & guard_on});
    end
    chk("wrap_ram_000", {28'd0, ram[12'h000]}, 32'hA);
    chk("wrap_ram_0ff", {28'd0, ram[12'h0FF]}, 32'hB);
    chk("wrap_ram_0fe", {28'd0, ram[12'h0FE]}, 32'hC);

    // Simultaneous push and pop: push wins.
    load_sp(8'h80);
    exec(1'b1, 1'b1, 1'b1, 12'h5A3, 1'b0);
    // Requests and sp_load while busy are ignored.
    exec(1'b1, 1'b0, 1'b0, 12'h3C9, 1'b1);
    exec(1'b0, 1'b1, 1'b0, 12'h000, 1'b1);

    // Reset during POP_PCP.
    load_sp(8'h44);
    @(negedge clk);
    start_pop = 1'b1;
    @(negedge clk);
    start_pop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_pop_reading", {31'd0, mem_re}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    ref_sp = 8'h00; ref_pc = 12'h000; ref_fault = 1'b0;
    load_sp(8'h44);
    exec(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);

    // Randomized operations against the model.
    for (int it = 0; it < 150; it++) begin
      int r;
      logic [7:0] v;
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        case ($urandom_range(0, 3))
          0:       v = 8'($urandom_range(0, 3));
          1:       v = 8'hFC + 8'($urandom_range(0, 3));
          default: v = 8'($urandom);
        endcase
        load_sp(v);
      end else if (r <= 5) begin
        exec(1'b1, 1'b0, 1'b0, 12'($urandom), 1'b0);
      end else if (r <= 8) begin
        exec(1'b0, 1'b1, 1'($urandom), 12'h000, 1'b0);
      end else begin
        exec(1'b1, 1'b1, 1'($urandom), 12'($urandom), 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
